// File: rtl/fisher_yates_shuffler_pkg.sv
// Shared definitions for the Fisher-Yates shuffler: LFSR constants,
// FSM state type and the index-draw helper.
package shuffle_pkg;

    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHUFFLE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Scales an 8-bit random draw onto 0..idx with a multiply and shift
    // instead of a divider; the small modulo bias is accepted.
    function automatic logic [7:0] pick_index(input logic [7:0] r, input logic [7:0] idx);
        logic [15:0] prod;
        prod = 16'(r) * 16'({1'b0, idx} + 9'd1);
        return 8'(prod >> 8);
    endfunction

endpackage

// File: rtl/fisher_yates_shuffler_if.sv
// Handshake bundle between a vector producer/consumer and the shuffler.
//
// Handshake rules (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holds valid and its data
// stable until the transfer; ready may change freely and never depends
// combinationally on valid. seed_load is sampled only while in_ready is high.
interface fisher_yates_shuffler_if #(
    parameter int BW = 8,
    parameter int N  = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [N*BW-1:0] inNum;
    logic            seed_load;
    logic [15:0]     seed;
    logic            out_valid;
    logic            out_ready;
    logic [N*BW-1:0] outNum;

    // Side that supplies vectors and consumes permutations.
    modport master (
        output in_valid, inNum, seed_load, seed, out_ready,
        input  in_ready, out_valid, outNum
    );

    // The shuffler itself.
    modport slave (
        input  in_valid, inNum, seed_load, seed, out_ready,
        output in_ready, out_valid, outNum
    );
endinterface

// File: rtl/fisher_yates_shuffler_lfsr16_galois.sv
// 16-bit right-shifting Galois LFSR with synchronous load. A zero seed
// would lock the register at zero, so it is replaced by the default seed.
module lfsr16_galois
    import shuffle_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        step,
    output logic [15:0] value
);

    // Load has priority over step; the register holds otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value <= LFSR_DEFAULT;
        end else if (load) begin
            value <= (load_val == 16'h0000) ? LFSR_DEFAULT : load_val;
        end else if (step) begin
            value <= (value >> 1) ^ (value[0] ? LFSR_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/fisher_yates_shuffler.sv
// Sequential Fisher-Yates shuffler: accepts one N-element vector, performs
// one swap per clock from the top index down to 1, then presents the
// permutation until the consumer takes it.
module fisher_yates_shuffler
    import shuffle_pkg::*;
#(
    parameter  int BW = 8,
    parameter  int N  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    fisher_yates_shuffler_if.slave  bus,
    output state_t                  state
);

    state_t            state_nxt;
    logic [BW-1:0]     arr     [N];
    logic [BW-1:0]     arr_nxt [N];
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_nxt;
    logic [IW-1:0]     j;
    logic [15:0]       lfsr;
    logic              lfsr_load;
    logic              lfsr_step;
    logic              load_out;
    logic [N*BW-1:0]   out_num;

    lfsr16_galois u_lfsr (
        .clk      (clk),
        .rstn     (rstn),
        .load     (lfsr_load),
        .load_val (bus.seed),
        .step     (lfsr_step),
        .value    (lfsr)
    );

    // Swap partner drawn from the LFSR value before this cycle's advance.
    assign j = IW'(pick_index(lfsr[15:8], 8'(idx)));

    // Next state, next array contents and LFSR control.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        arr_nxt   = arr;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        load_out  = 1'b0;
        case (state)
            IDLE: begin
                lfsr_load = bus.seed_load;
                if (bus.in_valid) begin
                    for (int k = 0; k < N; k++) begin
                        arr_nxt[k] = bus.inNum[k*BW +: BW];
                    end
                    idx_nxt = IW'(N - 1);
                    if (N == 1) begin
                        state_nxt = DONE;
                        load_out  = 1'b1;
                    end else begin
                        state_nxt = SHUFFLE;
                    end
                end
            end
            SHUFFLE: begin
                // When j equals idx both writes carry the same value.
                arr_nxt[idx] = arr[j];
                arr_nxt[j]   = arr[idx];
                lfsr_step    = 1'b1;
                idx_nxt      = idx - IW'(1);
                if (idx == IW'(1)) begin
                    state_nxt = DONE;
                    load_out  = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, working array and the registered output vector.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            idx     <= '0;
            out_num <= '0;
            for (int k = 0; k < N; k++) begin
                arr[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            for (int k = 0; k < N; k++) begin
                arr[k] <= arr_nxt[k];
            end
            if (load_out) begin
                for (int k = 0; k < N; k++) begin
                    out_num[k*BW +: BW] <= arr_nxt[k];
                end
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.outNum    = out_num;

endmodule
